// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared encodings, field positions and control bundle type for
//               the MIPS decode / ID-EX pipeline stage.
// Revision    : 1.0  initial release
// ============================================================================
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 5;

    // DatatoReg write-back source select; 2'b11 is reserved and behaves as ALU
    localparam logic [1:0] DTR_ALU = 2'b00;
    localparam logic [1:0] DTR_MEM = 2'b01;
    localparam logic [1:0] DTR_PC4 = 2'b10;

    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_AW-1:0] REG_RA   = 5'd31;

    // Instruction field positions
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;

    // Decoded control bundle carried from IF/ID into ID/EX
    typedef struct packed {
        logic       RegDst;
        logic       ALUSrc_B;
        logic       Jal;
        logic       RegWrite;
        logic       mem_w;
        logic       CPU_MIO;
        logic [1:0] DatatoReg;
        logic [1:0] Branch;
        logic [2:0] ALU_Control;
    } ctrl_t;

    // A bubble must never write a register, touch memory, jump or branch
    localparam ctrl_t CTRL_BUBBLE = '0;

    function automatic logic [DATA_W-1:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : MIPS general-purpose register file, 2 async reads, 1 sync
//               write, write-back bypass on reads, r0 hard-wired to zero,
//               asynchronous active-low clear of all entries.
// Revision    : 1.0  initial release
// ============================================================================
module reg_file
    import mips_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_AW-1:0]    rs_addr,
    input  logic [REG_AW-1:0]    rt_addr,
    output logic [DATA_W-1:0]    rs_data,
    output logic [DATA_W-1:0]    rt_data,
    input  logic                 we,
    input  logic [REG_AW-1:0]    waddr,
    input  logic [DATA_W-1:0]    wdata
);

    logic [DATA_W-1:0] regs [DEPTH];

    // A read of the register being written this cycle sees the new value,
    // so the writer and the reader need not be separated by a cycle.
    function automatic logic [DATA_W-1:0] read_port(input logic [REG_AW-1:0] a);
        if (a == REG_ZERO)
            return '0;
        else if (we && (waddr == a))
            return wdata;
        else
            return regs[a];
    endfunction

    // Storage: clear everything on reset, otherwise single write port (r0 ignored)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != REG_ZERO)) begin
            regs[waddr] <= wdata;
        end
    end

    // Two combinational read ports with bypass
    always_comb begin
        rs_data = read_port(rs_addr);
        rt_data = read_port(rt_addr);
    end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : MIPS decode stage. Splits instruction fields, reads the
//               register file, resolves the destination register, detects
//               load-use hazards and loads the ID/EX pipeline register
//               (or a bubble on hazard / flush).
// Revision    : 1.0  initial release
// ============================================================================
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int          RF_DEPTH = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic [31:0] IF_ID_PC,
    input  logic [31:0] IF_ID_inst,
    input  logic        IF_ID_RegDst,
    input  logic        IF_ID_ALUSrc_B,
    input  logic        IF_ID_Jal,
    input  logic        IF_ID_RegWrite,
    input  logic        IF_ID_mem_w,
    input  logic        IF_ID_CPU_MIO,
    input  logic [1:0]  IF_ID_DatatoReg,
    input  logic [1:0]  IF_ID_Branch,
    input  logic [2:0]  IF_ID_ALU_Control,

    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,

    input  logic        flush,
    output logic        Enable,

    output logic [31:0] ID_EX_PC,
    output logic [31:0] ID_EX_rs_data,
    output logic [31:0] ID_EX_rt_data,
    output logic [31:0] ID_EX_imm,
    output logic [4:0]  ID_EX_rs,
    output logic [4:0]  ID_EX_rt,
    output logic [4:0]  ID_EX_wreg,
    output logic [4:0]  ID_EX_shamt,
    output logic        ID_EX_RegDst,
    output logic        ID_EX_ALUSrc_B,
    output logic        ID_EX_Jal,
    output logic        ID_EX_RegWrite,
    output logic        ID_EX_mem_w,
    output logic        ID_EX_CPU_MIO,
    output logic [1:0]  ID_EX_DatatoReg,
    output logic [1:0]  ID_EX_Branch,
    output logic [2:0]  ID_EX_ALU_Control
);

    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [4:0]  wreg;
    logic [31:0] imm;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        load_use;
    logic        bubble;
    ctrl_t       dec_ctrl;
    ctrl_t       ex_ctrl;
    logic        unused_opfunct;

    assign rs    = IF_ID_inst[RS_MSB:RS_LSB];
    assign rt    = IF_ID_inst[RT_MSB:RT_LSB];
    assign rd    = IF_ID_inst[RD_MSB:RD_LSB];
    assign shamt = IF_ID_inst[SHAMT_MSB:SHAMT_LSB];
    assign imm   = sign_ext16(IF_ID_inst[IMM_MSB:IMM_LSB]);

    // Opcode and funct are already decoded upstream into the control inputs
    assign unused_opfunct = ^{IF_ID_inst[31:26], IF_ID_inst[5:0]};

    assign dec_ctrl = '{
        RegDst:      IF_ID_RegDst,
        ALUSrc_B:    IF_ID_ALUSrc_B,
        Jal:         IF_ID_Jal,
        RegWrite:    IF_ID_RegWrite,
        mem_w:       IF_ID_mem_w,
        CPU_MIO:     IF_ID_CPU_MIO,
        DatatoReg:   IF_ID_DatatoReg,
        Branch:      IF_ID_Branch,
        ALU_Control: IF_ID_ALU_Control
    };

    reg_file #(
        .DEPTH   (RF_DEPTH)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .rs_addr (rs),
        .rt_addr (rt),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .we      (wb_we),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    // Destination select: link register for jal, rd for R-type, rt otherwise
    always_comb begin
        wreg = rt;
        if (IF_ID_Jal)
            wreg = REG_RA;
        else if (IF_ID_RegDst)
            wreg = rd;
    end

    // Load in EX whose result is needed now; rt is compared even for I-type,
    // which may cause a harmless extra stall but never a missed one.
    always_comb begin
        load_use = (ex_ctrl.DatatoReg == DTR_MEM) && ex_ctrl.RegWrite &&
                   (ID_EX_wreg != REG_ZERO) &&
                   ((ID_EX_wreg == rs) || (ID_EX_wreg == rt));
        // A squashed instruction cannot consume anything, so flush wins
        bubble   = flush || load_use;
        Enable   = flush || !load_use;
    end

    // ID/EX pipeline register: reset state, bubble, or captured decode results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ID_EX_PC      <= RESET_PC;
            ID_EX_rs_data <= '0;
            ID_EX_rt_data <= '0;
            ID_EX_imm     <= '0;
            ID_EX_rs      <= '0;
            ID_EX_rt      <= '0;
            ID_EX_wreg    <= '0;
            ID_EX_shamt   <= '0;
            ex_ctrl       <= CTRL_BUBBLE;
        end else if (bubble) begin
            ID_EX_PC      <= '0;
            ID_EX_rs_data <= '0;
            ID_EX_rt_data <= '0;
            ID_EX_imm     <= '0;
            ID_EX_rs      <= '0;
            ID_EX_rt      <= '0;
            ID_EX_wreg    <= '0;
            ID_EX_shamt   <= '0;
            ex_ctrl       <= CTRL_BUBBLE;
        end else begin
            ID_EX_PC      <= IF_ID_PC;
            ID_EX_rs_data <= rs_data;
            ID_EX_rt_data <= rt_data;
            ID_EX_imm     <= imm;
            ID_EX_rs      <= rs;
            ID_EX_rt      <= rt;
            ID_EX_wreg    <= wreg;
            ID_EX_shamt   <= shamt;
            ex_ctrl       <= dec_ctrl;
        end
    end

    assign ID_EX_RegDst      = ex_ctrl.RegDst;
    assign ID_EX_ALUSrc_B    = ex_ctrl.ALUSrc_B;
    assign ID_EX_Jal         = ex_ctrl.Jal;
    assign ID_EX_RegWrite    = ex_ctrl.RegWrite;
    assign ID_EX_mem_w       = ex_ctrl.mem_w;
    assign ID_EX_CPU_MIO     = ex_ctrl.CPU_MIO;
    assign ID_EX_DatatoReg   = ex_ctrl.DatatoReg;
    assign ID_EX_Branch      = ex_ctrl.Branch;
    assign ID_EX_ALU_Control = ex_ctrl.ALU_Control;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Self-checking bench for id_ex_stage. Expected ID/EX contents
//               are pushed to a scoreboard when an instruction is driven and
//               popped after the capturing edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wreg;
        logic [4:0]  shamt;
        ctrl_t       c;
        logic        bubble;
    } exp_t;

    localparam ctrl_t C_NONE = '0;
    localparam ctrl_t C_ADDI = '{RegDst:1'b0, ALUSrc_B:1'b1, Jal:1'b0, RegWrite:1'b1, mem_w:1'b0,
                                 CPU_MIO:1'b0, DatatoReg:2'b00, Branch:2'b00, ALU_Control:3'b010};
    localparam ctrl_t C_ADD  = '{RegDst:1'b1, ALUSrc_B:1'b0, Jal:1'b0, RegWrite:1'b1, mem_w:1'b0,
                                 CPU_MIO:1'b0, DatatoReg:2'b00, Branch:2'b00, ALU_Control:3'b010};
    localparam ctrl_t C_LW   = '{RegDst:1'b0, ALUSrc_B:1'b1, Jal:1'b0, RegWrite:1'b1, mem_w:1'b0,
                                 CPU_MIO:1'b1, DatatoReg:2'b01, Branch:2'b00, ALU_Control:3'b010};
    localparam ctrl_t C_RSV  = '{RegDst:1'b0, ALUSrc_B:1'b1, Jal:1'b0, RegWrite:1'b1, mem_w:1'b0,
                                 CPU_MIO:1'b1, DatatoReg:2'b11, Branch:2'b00, ALU_Control:3'b010};
    localparam ctrl_t C_JAL  = '{RegDst:1'b0, ALUSrc_B:1'b0, Jal:1'b1, RegWrite:1'b1, mem_w:1'b0,
                                 CPU_MIO:1'b0, DatatoReg:2'b10, Branch:2'b00, ALU_Control:3'b000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] IF_ID_PC = '0;
    logic [31:0] IF_ID_inst = '0;
    ctrl_t       in_c = '0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        flush = 1'b0;

    logic        Enable;
    logic [31:0] ID_EX_PC, ID_EX_rs_data, ID_EX_rt_data, ID_EX_imm;
    logic [4:0]  ID_EX_rs, ID_EX_rt, ID_EX_wreg, ID_EX_shamt;
    logic        ID_EX_RegDst, ID_EX_ALUSrc_B, ID_EX_Jal, ID_EX_RegWrite, ID_EX_mem_w, ID_EX_CPU_MIO;
    logic [1:0]  ID_EX_DatatoReg, ID_EX_Branch;
    logic [2:0]  ID_EX_ALU_Control;

    exp_t        sb [$];
    exp_t        mprev = '0;
    logic [31:0] mrf [32];
    int          total = 0;
    int          bad = 0;

    id_ex_stage #(
        .RF_DEPTH          (32),
        .RESET_PC          (RST_PC)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .IF_ID_PC          (IF_ID_PC),
        .IF_ID_inst        (IF_ID_inst),
        .IF_ID_RegDst      (in_c.RegDst),
        .IF_ID_ALUSrc_B    (in_c.ALUSrc_B),
        .IF_ID_Jal         (in_c.Jal),
        .IF_ID_RegWrite    (in_c.RegWrite),
        .IF_ID_mem_w       (in_c.mem_w),
        .IF_ID_CPU_MIO     (in_c.CPU_MIO),
        .IF_ID_DatatoReg   (in_c.DatatoReg),
        .IF_ID_Branch      (in_c.Branch),
        .IF_ID_ALU_Control (in_c.ALU_Control),
        .wb_we             (wb_we),
        .wb_addr           (wb_addr),
        .wb_data           (wb_data),
        .flush             (flush),
        .Enable            (Enable),
        .ID_EX_PC          (ID_EX_PC),
        .ID_EX_rs_data     (ID_EX_rs_data),
        .ID_EX_rt_data     (ID_EX_rt_data),
        .ID_EX_imm         (ID_EX_imm),
        .ID_EX_rs          (ID_EX_rs),
        .ID_EX_rt          (ID_EX_rt),
        .ID_EX_wreg        (ID_EX_wreg),
        .ID_EX_shamt       (ID_EX_shamt),
        .ID_EX_RegDst      (ID_EX_RegDst),
        .ID_EX_ALUSrc_B    (ID_EX_ALUSrc_B),
        .ID_EX_Jal         (ID_EX_Jal),
        .ID_EX_RegWrite    (ID_EX_RegWrite),
        .ID_EX_mem_w       (ID_EX_mem_w),
        .ID_EX_CPU_MIO     (ID_EX_CPU_MIO),
        .ID_EX_DatatoReg   (ID_EX_DatatoReg),
        .ID_EX_Branch      (ID_EX_Branch),
        .ID_EX_ALU_Control (ID_EX_ALU_Control)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0)
            return 32'h0;
        else if (wb_we && (wb_addr == a))
            return wb_data;
        else
            return mrf[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mrf[i] = 32'h0;
        mprev = '0;
        sb.delete();
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] inst, input ctrl_t c,
                         input logic fl, input logic we, input logic [4:0] wa, input logic [31:0] wd);
        IF_ID_PC   = pc;
        IF_ID_inst = inst;
        in_c       = c;
        flush      = fl;
        wb_we      = we;
        wb_addr    = wa;
        wb_data    = wd;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"},   ID_EX_PC, RST_PC);
        chk({tag, "_data"}, ID_EX_rs_data | ID_EX_rt_data | ID_EX_imm, 32'h0);
        chk({tag, "_idx"},  32'({ID_EX_rs, ID_EX_rt, ID_EX_wreg, ID_EX_shamt}), 32'h0);
        chk({tag, "_ctrl"}, 32'({ID_EX_RegDst, ID_EX_ALUSrc_B, ID_EX_Jal, ID_EX_RegWrite, ID_EX_mem_w,
                                 ID_EX_CPU_MIO, ID_EX_DatatoReg, ID_EX_Branch, ID_EX_ALU_Control}), 32'h0);
        chk({tag, "_enable"}, 32'(Enable), 32'h1);
    endtask

    // One decode cycle: predict, push, clock, pop and compare
    task automatic cycle();
        exp_t        e;
        exp_t        got;
        logic [4:0]  s, t, d;
        logic        hz;
        s  = IF_ID_inst[25:21];
        t  = IF_ID_inst[20:16];
        d  = IF_ID_inst[15:11];
        hz = (mprev.c.DatatoReg == 2'b01) && mprev.c.RegWrite && (mprev.wreg != 5'd0) &&
             ((mprev.wreg == s) || (mprev.wreg == t));
        e = '0;
        e.bubble = flush || hz;
        if (!e.bubble) begin
            e.pc      = IF_ID_PC;
            e.rs_data = model_read(s);
            e.rt_data = model_read(t);
            e.imm     = {{16{IF_ID_inst[15]}}, IF_ID_inst[15:0]};
            e.rs      = s;
            e.rt      = t;
            e.wreg    = in_c.Jal ? 5'd31 : (in_c.RegDst ? d : t);
            e.shamt   = IF_ID_inst[10:6];
            e.c       = in_c;
        end
        sb.push_back(e);
        #1;
        chk("enable", 32'(Enable), 32'(flush || !hz));
        @(posedge clk);
        if (wb_we && (wb_addr != 5'd0)) mrf[wb_addr] = wb_data;
        mprev = e;
        #1;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            got = sb.pop_front();
            chk("RegWrite",  32'(ID_EX_RegWrite),  32'(got.c.RegWrite));
            chk("mem_w",     32'(ID_EX_mem_w),     32'(got.c.mem_w));
            chk("Jal",       32'(ID_EX_Jal),       32'(got.c.Jal));
            chk("Branch",    32'(ID_EX_Branch),    32'(got.c.Branch));
            chk("DatatoReg", 32'(ID_EX_DatatoReg), 32'(got.c.DatatoReg));
            if (!got.bubble) begin
                chk("pc",      ID_EX_PC,      got.pc);
                chk("rs_data", ID_EX_rs_data, got.rs_data);
                chk("rt_data", ID_EX_rt_data, got.rt_data);
                chk("imm",     ID_EX_imm,     got.imm);
                chk("rs",      32'(ID_EX_rs),    32'(got.rs));
                chk("rt",      32'(ID_EX_rt),    32'(got.rt));
                chk("wreg",    32'(ID_EX_wreg),  32'(got.wreg));
                chk("shamt",   32'(ID_EX_shamt), 32'(got.shamt));
                chk("misc_ctrl", 32'({ID_EX_RegDst, ID_EX_ALUSrc_B, ID_EX_CPU_MIO, ID_EX_ALU_Control}),
                    32'({got.c.RegDst, got.c.ALUSrc_B, got.c.CPU_MIO, got.c.ALU_Control}));
            end
        end
    endtask

    initial begin
        model_reset();

        // Reset state
        @(posedge clk);
        #1;
        chk_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // addi $5,$0,-4
        drive(32'h100, 32'h2005FFFC, C_ADDI, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();
        chk("addi_imm", ID_EX_imm, 32'hFFFF_FFFC);
        chk("addi_wreg", 32'(ID_EX_wreg), 32'd5);
        chk("addi_regwrite", 32'(ID_EX_RegWrite), 32'd1);

        // Write-back bypass: add $10,$7,$0 while r7 is written
        drive(32'h104, 32'h00E05020, C_ADD, 1'b0, 1'b1, 5'd7, 32'hDEADBEEF);
        cycle();
        chk("bypass_rs_data", ID_EX_rs_data, 32'hDEAD_BEEF);

        // lw $8,0($0) while r1 is written, then dependent add $9,$8,$1
        drive(32'h108, 32'h8C080000, C_LW, 1'b0, 1'b1, 5'd1, 32'h0000_0011);
        cycle();
        drive(32'h10C, 32'h01014820, C_ADD, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();
        chk("stall_bubble_regwrite", 32'(ID_EX_RegWrite), 32'd0);
        cycle();
        chk("after_stall_wreg", 32'(ID_EX_wreg), 32'd9);
        chk("after_stall_rt_data", ID_EX_rt_data, 32'h0000_0011);

        // Load-use coinciding with flush
        drive(32'h110, 32'h8C080000, C_LW, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();
        drive(32'h114, 32'h01014820, C_ADD, 1'b1, 1'b0, 5'd0, 32'h0);
        cycle();
        chk("flush_bubble_regwrite", 32'(ID_EX_RegWrite), 32'd0);
        drive(32'h118, 32'h01014820, C_ADD, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();

        // Write to r0 is ignored, same-cycle and later reads
        drive(32'h11C, 32'h00005020, C_ADD, 1'b0, 1'b1, 5'd0, 32'h0000_1234);
        cycle();
        chk("r0_same_cycle", ID_EX_rs_data, 32'h0);
        drive(32'h120, 32'h00005020, C_ADD, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();
        chk("r0_later", ID_EX_rs_data, 32'h0);

        // jal goes to $31
        drive(32'h200, 32'h0C000010, C_JAL, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();
        chk("jal_wreg", 32'(ID_EX_wreg), 32'd31);

        // Reserved DatatoReg does not count as a load
        drive(32'h204, 32'h8C080000, C_RSV, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();
        drive(32'h208, 32'h01014820, C_ADD, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();

        // Load into r0 never stalls
        drive(32'h20C, 32'h8C000000, C_LW, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();
        drive(32'h210, 32'h00014820, C_ADD, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();

        // Asynchronous reset in the middle of a stall cycle
        drive(32'h300, 32'h8C080000, C_LW, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();
        drive(32'h304, 32'h01014820, C_ADD, 1'b0, 1'b0, 5'd0, 32'h0);
        #1;
        chk("pre_reset_stall", 32'(Enable), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state("async_reset");
        @(posedge clk);
        #1;
        chk_reset_state("held_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Register file was cleared: r7 reads 0
        drive(32'h400, 32'h00E05020, C_ADD, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();
        chk("rf_cleared_r7", ID_EX_rs_data, 32'h0);

        drive(32'h404, 32'h0, C_NONE, 1'b0, 1'b0, 5'd0, 32'h0);
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
